vga_timing_generator: RTL and testbench
=======================================

Name: vga_timing_generator

Overview:
- Produces the VGA raster scan for the display path: pixel column/row counters, display_enable, and horizontal/vertical sync pulses. Default timing is 640x480 at 60 Hz from the 25 MHz vga_clock.
- row, column and display_enable feed the VGA drawer/colour stage directly.
- The colour stage registers RGB one cycle after row/column, so hsync/vsync pass through a delay line to stay aligned with the colour outputs at the connector.
- A frame_start pulse and a frame counter let game logic advance once per frame.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_ACTIVE, 0, level of hsync/vsync while asserted (0 = active-low)
SYNC_DELAY, 1, extra cycles applied to hsync/vsync relative to row/column/display_enable (0..4)

Ports:
vga_clock  input  1  pixel clock
reset  input  1  asynchronous, active-low reset
row  output  int (32)  current line, 0..V_TOTAL-1
column  output  int (32)  current pixel, 0..H_TOTAL-1
display_enable  output  1  high when column < H_VISIBLE and row < V_VISIBLE
hsync  output  1  horizontal sync, polarity SYNC_ACTIVE, delayed by SYNC_DELAY
vsync  output  1  vertical sync, polarity SYNC_ACTIVE, delayed by SYNC_DELAY
frame_start  output  1  one-cycle pulse coincident with row=0, column=0
frame_count  output  16  completed-frame counter, wraps

Behaviour:
- Totals: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525).
- Internal counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1) are the current position.
- Each rising edge:
  - all outputs register values decoded from the current (h,v);
  - h increments.
- Wrap rules:
  - h = H_TOTAL-1: h -> 0 and v increments.
  - h = H_TOTAL-1 and v = V_TOTAL-1: both -> 0.
  - There are no other transitions.
- Register-stage outputs: column <= h; row <= v; display_enable <= (h < H_VISIBLE) && (v < V_VISIBLE).
- Sync windows:
  - Raw hsync is asserted for H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751.
  - Raw vsync is asserted for V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC, i.e. 490..491, for the whole of each such line.
  - Raw syncs are registered in the same stage as column, then pass through a SYNC_DELAY-deep shift register.
  - SYNC_DELAY=0 means hsync/vsync align with column/row.
- Phase FSM per axis: VISIBLE -> FRONT -> SYNC -> BACK -> VISIBLE. It advances on the porch boundaries above, and the sync windows above are derived from it. The vertical FSM steps only on horizontal wrap.
- frame_start <= (h==0 && v==0), so it is high in the same cycle that column=0, row=0 are presented.
- frame_count increments by 1 on the edge where h=H_TOTAL-1 and v=V_TOTAL-1. It wraps 65535 -> 0.
- Reset (reset low, asynchronous, any time including mid-frame):
  - h=0, v=0, both FSMs in VISIBLE;
  - row=0, column=0, display_enable=0, frame_start=0, frame_count=0;
  - hsync, vsync and every delay-line stage at the inactive level (~SYNC_ACTIVE).
  - All remain held while reset is low.
- First rising edge after reset release presents column=0, row=0, display_enable=1, frame_start=1. This first frame_start does not increment frame_count.
- Output values are independent of visibility; downstream gates colour with display_enable.

Test Plan:
- Reset values: hold reset low 10 cycles -> row=0, column=0, display_enable=0, hsync=vsync=1, frame_start=0, frame_count=0. After release, first edge -> column=0, row=0, display_enable=1, frame_start=1.
- Horizontal timing (SYNC_DELAY=1):
  - display_enable falls on the edge presenting column=640;
  - hsync goes low one cycle after column=656 is presented and returns high one cycle after column=752 is presented (96 cycles low).
  - Then column 799 -> 0 and row 0 -> 1.
- Vertical timing:
  - vsync low for exactly 1600 cycles, starting one cycle after row=490, column=0 is presented;
  - display_enable stays 0 for all of rows 480..524.
  - Row 524, column 799 -> next edge presents row=0, column=0, frame_start=1.
- Frame statistics over 3 frames:
  - frame_start period exactly 420000 cycles;
  - display_enable high for exactly 307200 cycles per frame;
  - frame_count reads 1, 2, 3 at the successive frame_start pulses.
- Mid-frame reset: assert reset asynchronously at row=300, column=400 between clock edges -> outputs reach reset values without waiting for a clock edge. After release, the scan restarts at (0,0) with frame_start=1 and frame_count=0.
- Parameter variants:
  - SYNC_DELAY=0 -> hsync low exactly while column is 656..751.
  - SYNC_ACTIVE=1 -> sync polarity inverted, reset level 0.

Source files
------------

// File: rtl/vga_timing_generator.sv
// rtl/vga_timing_generator.sv - VGA raster timing generator with phase FSMs and sync delay line
module vga_timing_generator #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter bit SYNC_ACTIVE = 1'b0,
  parameter int SYNC_DELAY  = 1
) (
  input  logic        vga_clock,
  input  logic        reset,
  output logic [31:0] row,
  output logic [31:0] column,
  output logic        display_enable,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  // Boundary positions, held unsigned so counter comparisons stay width-matched.
  localparam logic [31:0] H_FRONT_START = 32'(H_VISIBLE);
  localparam logic [31:0] H_SYNC_START  = 32'(H_VISIBLE + H_FRONT);
  localparam logic [31:0] H_BACK_START  = 32'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [31:0] H_LAST        = 32'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [31:0] V_FRONT_START = 32'(V_VISIBLE);
  localparam logic [31:0] V_SYNC_START  = 32'(V_VISIBLE + V_FRONT);
  localparam logic [31:0] V_BACK_START  = 32'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [31:0] V_LAST        = 32'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam bit          SYNC_IDLE     = ~SYNC_ACTIVE;

  typedef enum logic [1:0] {
    PH_VISIBLE,
    PH_FRONT,
    PH_SYNC,
    PH_BACK
  } phase_t;

  logic [31:0] h;
  logic [31:0] v;
  logic [31:0] h_next;
  logic [31:0] v_next;
  logic        h_wrap;
  logic        v_wrap;
  logic        frame_wrap;
  phase_t      h_phase;
  phase_t      v_phase;
  logic        hsync_raw;
  logic        vsync_raw;

  // Stage 0 of each line is the register aligned with column/row; stage SYNC_DELAY drives the pin.
  logic [SYNC_DELAY:0] hsync_line;
  logic [SYNC_DELAY:0] vsync_line;

  assign h_wrap     = (h == H_LAST);
  assign v_wrap     = (v == V_LAST);
  assign frame_wrap = h_wrap && v_wrap;

  // Next scan position: h wraps every line, v advances only when h wraps.
  always_comb begin
    h_next = h + 32'd1;
    v_next = v;
    if (h_wrap) begin
      h_next = 32'd0;
      v_next = v_wrap ? 32'd0 : v + 32'd1;
    end
  end

  // Raw sync levels come straight from the phase FSMs.
  always_comb begin
    hsync_raw = (h_phase == PH_SYNC) ? SYNC_ACTIVE : SYNC_IDLE;
    vsync_raw = (v_phase == PH_SYNC) ? SYNC_ACTIVE : SYNC_IDLE;
  end

  // Position counters for the current pixel.
  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      h <= 32'd0;
      v <= 32'd0;
    end else begin
      h <= h_next;
      v <= v_next;
    end
  end

  // Horizontal phase tracks which region the current h lies in.
  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      h_phase <= PH_VISIBLE;
    end else begin
      case (h_phase)
        PH_VISIBLE: if (h_next == H_FRONT_START) h_phase <= PH_FRONT;
        PH_FRONT:   if (h_next == H_SYNC_START)  h_phase <= PH_SYNC;
        PH_SYNC:    if (h_next == H_BACK_START)  h_phase <= PH_BACK;
        PH_BACK:    if (h_wrap)                  h_phase <= PH_VISIBLE;
        default:                                 h_phase <= PH_VISIBLE;
      endcase
    end
  end

  // Vertical phase steps only at the end of each line.
  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      v_phase <= PH_VISIBLE;
    end else if (h_wrap) begin
      case (v_phase)
        PH_VISIBLE: if (v_next == V_FRONT_START) v_phase <= PH_FRONT;
        PH_FRONT:   if (v_next == V_SYNC_START)  v_phase <= PH_SYNC;
        PH_SYNC:    if (v_next == V_BACK_START)  v_phase <= PH_BACK;
        PH_BACK:    if (v_wrap)                  v_phase <= PH_VISIBLE;
        default:                                 v_phase <= PH_VISIBLE;
      endcase
    end
  end

  // Output register stage decoded from the current position.
  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      column         <= 32'd0;
      row            <= 32'd0;
      display_enable <= 1'b0;
      frame_start    <= 1'b0;
      frame_count    <= 16'd0;
    end else begin
      column         <= h;
      row            <= v;
      display_enable <= (h_phase == PH_VISIBLE) && (v_phase == PH_VISIBLE);
      frame_start    <= (h == 32'd0) && (v == 32'd0);
      if (frame_wrap) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

  generate
    if (SYNC_DELAY == 0) begin : g_sync_direct
      // Syncs registered alongside column/row with no extra delay.
      always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
          hsync_line <= SYNC_IDLE;
          vsync_line <= SYNC_IDLE;
        end else begin
          hsync_line <= hsync_raw;
          vsync_line <= vsync_raw;
        end
      end
    end else begin : g_sync_delayed
      // Shift syncs so they meet the colour stage's registered RGB at the connector.
      always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
          hsync_line <= {(SYNC_DELAY + 1){SYNC_IDLE}};
          vsync_line <= {(SYNC_DELAY + 1){SYNC_IDLE}};
        end else begin
          hsync_line <= {hsync_line[SYNC_DELAY-1:0], hsync_raw};
          vsync_line <= {vsync_line[SYNC_DELAY-1:0], vsync_raw};
        end
      end
    end
  endgenerate

  assign hsync = hsync_line[SYNC_DELAY];
  assign vsync = vsync_line[SYNC_DELAY];

endmodule

// File: tb/tb_vga_timing_generator.sv
// tb/tb_vga_timing_generator.sv - scoreboard bench for vga_timing_generator over four parameter sets
module tb_vga_timing_generator;

  localparam int NINST = 4;

  // Instance 0 frame statistics (small timing: 25 x 17).
  localparam int A_FT    = 25 * 17;
  localparam int A_DE    = 16 * 10;
  localparam int A_VSLOW = 2 * 25;

  logic        clk;
  logic        reset;
  logic [31:0] row_o [NINST];
  logic [31:0] col_o [NINST];
  logic        de_o  [NINST];
  logic        hs_o  [NINST];
  logic        vs_o  [NINST];
  logic        fs_o  [NINST];
  logic [15:0] fc_o  [NINST];

  typedef struct {
    int          idx;
    int          t;
    logic [31:0] row;
    logic [31:0] col;
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [15:0] fc;
  } exp_t;

  exp_t sb_q[$];
  int   t;
  int   n_pass;
  int   n_total;
  bit   stats_on;
  int   st_cyc;
  int   st_de;
  int   st_vs;
  int   st_frames;
  bit   st_prev;

  vga_timing_generator #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(4),
    .V_VISIBLE(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .SYNC_ACTIVE(1'b0), .SYNC_DELAY(1)
  ) dut_a (
    .vga_clock(clk), .reset(reset), .row(row_o[0]), .column(col_o[0]),
    .display_enable(de_o[0]), .hsync(hs_o[0]), .vsync(vs_o[0]),
    .frame_start(fs_o[0]), .frame_count(fc_o[0])
  );

  vga_timing_generator #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(4),
    .V_VISIBLE(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .SYNC_ACTIVE(1'b0), .SYNC_DELAY(0)
  ) dut_b (
    .vga_clock(clk), .reset(reset), .row(row_o[1]), .column(col_o[1]),
    .display_enable(de_o[1]), .hsync(hs_o[1]), .vsync(vs_o[1]),
    .frame_start(fs_o[1]), .frame_count(fc_o[1])
  );

  vga_timing_generator #(
    .H_VISIBLE(12), .H_FRONT(3), .H_SYNC(4), .H_BACK(5),
    .V_VISIBLE(8), .V_FRONT(1), .V_SYNC(3), .V_BACK(2),
    .SYNC_ACTIVE(1'b1), .SYNC_DELAY(3)
  ) dut_c (
    .vga_clock(clk), .reset(reset), .row(row_o[2]), .column(col_o[2]),
    .display_enable(de_o[2]), .hsync(hs_o[2]), .vsync(vs_o[2]),
    .frame_start(fs_o[2]), .frame_count(fc_o[2])
  );

  vga_timing_generator dut_d (
    .vga_clock(clk), .reset(reset), .row(row_o[3]), .column(col_o[3]),
    .display_enable(de_o[3]), .hsync(hs_o[3]), .vsync(vs_o[3]),
    .frame_start(fs_o[3]), .frame_count(fc_o[3])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: outputs at cycle t after reset release (t<0 means in reset).
  function automatic exp_t model(int idx, int tt);
    int hv, hf, hsw, hb, vv, vf, vsw, vb, dly;
    int ht, vt, ft, pos, c, r, ts;
    bit act;
    exp_t e;
    case (idx)
      0: begin hv = 16; hf = 2; hsw = 3; hb = 4; vv = 10; vf = 2; vsw = 2; vb = 3; act = 0; dly = 1; end
      1: begin hv = 16; hf = 2; hsw = 3; hb = 4; vv = 10; vf = 2; vsw = 2; vb = 3; act = 0; dly = 0; end
      2: begin hv = 12; hf = 3; hsw = 4; hb = 5; vv = 8;  vf = 1; vsw = 3; vb = 2; act = 1; dly = 3; end
      default: begin hv = 640; hf = 16; hsw = 96; hb = 48; vv = 480; vf = 10; vsw = 2; vb = 33; act = 0; dly = 1; end
    endcase
    e.idx = idx;
    e.t   = tt;
    e.hs  = ~act;
    e.vs  = ~act;
    if (tt < 0) begin
      e.row = 0; e.col = 0; e.de = 0; e.fs = 0; e.fc = 0;
      return e;
    end
    ht  = hv + hf + hsw + hb;
    vt  = vv + vf + vsw + vb;
    ft  = ht * vt;
    pos = tt % ft;
    e.col = 32'(pos % ht);
    e.row = 32'(pos / ht);
    e.de  = ((pos % ht) < hv) && ((pos / ht) < vv);
    e.fs  = (pos == 0);
    e.fc  = 16'((tt + 1) / ft);
    ts = tt - dly;
    if (ts >= 0) begin
      c = (ts % ft) % ht;
      r = (ts % ft) / ht;
      if (c >= hv + hf && c < hv + hf + hsw) e.hs = act;
      if (r >= vv + vf && r < vv + vf + vsw) e.vs = act;
    end
    return e;
  endfunction

  task automatic check_val(string name, int idx, int tt, logic [31:0] got, logic [31:0] want);
    n_total++;
    if (got !== want)
      $display("FAIL %s inst=%0d t=%0d got=%0d expected=%0d", name, idx, tt, got, want);
    else
      n_pass++;
  endtask

  task automatic check_inst(string tag, exp_t e);
    int i;
    i = e.idx;
    check_val({tag, " row"}, i, e.t, row_o[i], e.row);
    check_val({tag, " column"}, i, e.t, col_o[i], e.col);
    check_val({tag, " display_enable"}, i, e.t, {31'b0, de_o[i]}, {31'b0, e.de});
    check_val({tag, " hsync"}, i, e.t, {31'b0, hs_o[i]}, {31'b0, e.hs});
    check_val({tag, " vsync"}, i, e.t, {31'b0, vs_o[i]}, {31'b0, e.vs});
    check_val({tag, " frame_start"}, i, e.t, {31'b0, fs_o[i]}, {31'b0, e.fs});
    check_val({tag, " frame_count"}, i, e.t, {16'b0, fc_o[i]}, {16'b0, e.fc});
  endtask

  // Expectation producer: one entry per instance after every rising edge.
  initial begin
    t = -1;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) t = -1;
      else        t = t + 1;
      for (int i = 0; i < NINST; i++) sb_q.push_back(model(i, t));
    end
  end

  // Monitor: compares presented outputs against queued expectations on the falling edge.
  initial begin
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int i = 0; i < NINST; i++) begin
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL scoreboard_empty inst=%0d got=0 entries expected=1", i);
        end else begin
          e = sb_q.pop_front();
          check_inst("scan", e);
        end
      end
    end
  end

  // Frame statistics for instance 0 while the stats window is open.
  initial begin
    st_cyc = 0; st_de = 0; st_vs = 0; st_frames = 0; st_prev = 0;
    forever begin
      @(negedge clk);
      if (stats_on) begin
        if (fs_o[0] === 1'b1) begin
          if (st_prev) begin
            check_val("frame_period", 0, t, 32'(st_cyc), 32'(A_FT));
            check_val("de_per_frame", 0, t, 32'(st_de), 32'(A_DE));
            check_val("vsync_low_per_frame", 0, t, 32'(st_vs), 32'(A_VSLOW));
          end
          check_val("fc_at_frame_start", 0, t, {16'b0, fc_o[0]}, 32'(st_frames));
          st_frames++;
          st_prev = 1;
          st_cyc = 0; st_de = 0; st_vs = 0;
        end
        st_cyc++;
        if (de_o[0] === 1'b1) st_de++;
        if (vs_o[0] === 1'b0) st_vs++;
      end
    end
  end

  // Stimulus: initial reset, three full frames, random mid-frame async resets.
  initial begin
    n_pass   = 0;
    n_total  = 0;
    stats_on = 0;
    reset    = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    stats_on = 1;
    repeat (3 * A_FT + 50) @(posedge clk);
    stats_on = 0;
    for (int k = 0; k < 2; k++) begin
      repeat ($urandom_range(60, 400)) @(posedge clk);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      for (int i = 0; i < NINST; i++) check_inst("async_reset", model(i, -1));
      repeat ($urandom_range(2, 6)) @(posedge clk);
      @(negedge clk);
      #2 reset = 1'b1;
    end
    repeat (A_FT + 30) @(posedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
